// File: rtl/mant_mul_seq.sv
// Radix-2 shift-add significand multiplier, one product bit per cycle.
// Valid/ready on both sides; result held in DONE until taken.
module mant_mul_seq #(
  parameter int WIDTH = 24,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_mant_a,
  input  logic [WIDTH-1:0]   i_mant_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_product
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH:0]   acc;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_sh;
  logic [WIDTH-1:0] mplr_sh;

  assign o_ready = (state == IDLE) && i_rst_n;
  assign accept  = i_valid && o_ready;
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  // acc[WIDTH] is always zero after a shift, so it adds nothing here
  assign sum     = acc + {1'b0, (mplr[0] ? mcand : '0)};
  assign acc_sh  = sum[WIDTH:1];
  assign mplr_sh = {sum[0], mplr[WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = BUSY;
      BUSY: if (last) state_n = DONE;
      DONE: if (i_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      cnt       <= '0;
      o_product <= '0;
      o_valid   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mcand <= i_mant_a;
            mplr  <= i_mant_b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          acc  <= {1'b0, acc_sh};
          mplr <= mplr_sh;
          cnt  <= cnt + 1'b1;
          if (last) begin
            o_product <= {acc_sh, mplr_sh};
            o_valid   <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) o_valid <= 1'b0;
        end
        default: o_valid <= 1'b0;
      endcase
    end
  end

endmodule
